// File: rtl/tone_scheduler.sv
// Debounced, fixed-priority eight-key tone generator (C4..C5 square wave).
// Optional macro TONE_SUSTAIN_EN adds a timed sustain tail after key release.
module tone_scheduler #(
  parameter int DEB_CYCLES     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int SCALE_SHIFT    = 0,
  parameter int SUSTAIN_CYCLES = 16
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic [7:0] iKeys,
  output logic       oTone,
  output logic       oActive,
  output logic [2:0] oKeyIdx,
  output logic       oLoad
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  if (DEB_CYCLES < 1 || GAP_CYCLES < 1 || SUSTAIN_CYCLES < 1) begin : g_bad_param
    $error("tone_scheduler: cycle-count parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_GAP
`ifdef TONE_SUSTAIN_EN
    , S_SUSTAIN
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       key_idx_q, key_idx_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [16:0]      div_q, div_d;
  logic             tone_q, tone_d;
  logic             load_q, load_d;

`ifdef TONE_SUSTAIN_EN
  localparam int SUS_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
  localparam logic [SUS_W-1:0] SUS_LAST = SUS_W'(SUSTAIN_CYCLES - 1);
  logic [SUS_W-1:0] sus_q, sus_d;
`endif

  function automatic logic [16:0] half_of(input logic [2:0] idx);
    logic [16:0] raw;
    case (idx)
      3'd0:    raw = 17'd95556;
      3'd1:    raw = 17'd85131;
      3'd2:    raw = 17'd75843;
      3'd3:    raw = 17'd71586;
      3'd4:    raw = 17'd63776;
      3'd5:    raw = 17'd56818;
      3'd6:    raw = 17'd50619;
      default: raw = 17'd47778;
    endcase
    raw = raw >> SCALE_SHIFT;
    if (raw == 17'd0) raw = 17'd1;
    return raw;
  endfunction

  logic [2:0]  winner;
  logic        any_key;
  logic        preempt;
  logic [7:0]  lower_mask;
  logic [16:0] half_m1;
  logic        div_wrap;

  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (iKeys[i]) winner = 3'(i);
    end
    any_key    = |iKeys;
    lower_mask = 8'((9'd1 << key_idx_q) - 9'd1);
    preempt    = |(iKeys & lower_mask);
    half_m1    = half_of(key_idx_q) - 17'd1;
    div_wrap   = (div_q == half_m1);
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    key_idx_d = key_idx_q;
    deb_d     = deb_q;
    gap_d     = gap_q;
    div_d     = div_q;
    tone_d    = tone_q;
    load_d    = 1'b0;
`ifdef TONE_SUSTAIN_EN
    sus_d     = sus_q;
`endif
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (any_key) begin
          state_d = S_ARM;
          cand_d  = winner;
          deb_d   = '0;
        end
      end
      S_ARM: begin
        if (!iKeys[cand_q]) begin
          state_d = S_IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d   = S_PLAY;
          key_idx_d = cand_q;
          div_d     = '0;
          tone_d    = 1'b0;
          load_d    = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (preempt) begin
          key_idx_d = winner;
          div_d     = '0;
          tone_d    = 1'b0;
          load_d    = 1'b1;
        end else begin
          // Divider also advances on the release cycle so a sustain tail stays in phase.
          div_d  = div_wrap ? 17'd0 : div_q + 17'd1;
          tone_d = div_wrap ? ~tone_q : tone_q;
          if (!iKeys[key_idx_q]) begin
`ifdef TONE_SUSTAIN_EN
            state_d = S_SUSTAIN;
            sus_d   = '0;
`else
            state_d = S_GAP;
            gap_d   = '0;
            tone_d  = 1'b0;
`endif
          end
        end
      end
`ifdef TONE_SUSTAIN_EN
      S_SUSTAIN: begin
        if (any_key) begin
          state_d = S_ARM;
          cand_d  = winner;
          deb_d   = '0;
          tone_d  = 1'b0;
        end else if (sus_q == SUS_LAST) begin
          state_d = S_GAP;
          gap_d   = '0;
          tone_d  = 1'b0;
        end else begin
          sus_d  = sus_q + 1'b1;
          div_d  = div_wrap ? 17'd0 : div_q + 17'd1;
          tone_d = div_wrap ? ~tone_q : tone_q;
        end
      end
`endif
      S_GAP: begin
        tone_d = 1'b0;
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        tone_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q   <= S_IDLE;
      cand_q    <= '0;
      key_idx_q <= '0;
      deb_q     <= '0;
      gap_q     <= '0;
      div_q     <= '0;
      tone_q    <= 1'b0;
      load_q    <= 1'b0;
`ifdef TONE_SUSTAIN_EN
      sus_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      key_idx_q <= key_idx_d;
      deb_q     <= deb_d;
      gap_q     <= gap_d;
      div_q     <= div_d;
      tone_q    <= tone_d;
      load_q    <= load_d;
`ifdef TONE_SUSTAIN_EN
      sus_q     <= sus_d;
`endif
    end
  end

  assign oTone   = tone_q;
  assign oKeyIdx = key_idx_q;
  assign oLoad   = load_q;
`ifdef TONE_SUSTAIN_EN
  assign oActive = (state_q == S_PLAY) || (state_q == S_SUSTAIN);
`else
  assign oActive = (state_q == S_PLAY);
`endif

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler with SCALE_SHIFT=14 (HALF: key0=5, key2=4, key3=4, key5=3, key7=2).
module tb_tone_scheduler;
  logic       iClk = 1'b0;
  logic       iReset;
  logic [7:0] iKeys;
  logic       oTone;
  logic       oActive;
  logic [2:0] oKeyIdx;
  logic       oLoad;

  int total = 0;
  int bad   = 0;

  tone_scheduler #(
    .DEB_CYCLES(4), .GAP_CYCLES(2), .SCALE_SHIFT(14), .SUSTAIN_CYCLES(16)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iKeys(iKeys),
    .oTone(oTone), .oActive(oActive), .oKeyIdx(oKeyIdx), .oLoad(oLoad)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Press key k from IDLE and advance to the first PLAY cycle.
  task automatic start_key(input int k);
    iKeys = 8'(1 << k);
    repeat (5) step();
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    iKeys  = 8'h00;
    step();
    step();
    total++; if (oTone !== 1'b0)   begin bad++; $display("FAIL reset_tone: got %b want 0", oTone); end
    total++; if (oActive !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", oActive); end
    total++; if (oKeyIdx !== 3'd0) begin bad++; $display("FAIL reset_keyidx: got %0d want 0", oKeyIdx); end
    total++; if (oLoad !== 1'b0)   begin bad++; $display("FAIL reset_load: got %b want 0", oLoad); end
    iReset = 1'b0;
    step();
  endtask

  task automatic test_play();
    int loads;
    logic exp_t;
    iKeys = 8'h01;
    for (int i = 1; i <= 5; i++) begin
      step();
      total++;
      if (oLoad !== (i == 5)) begin bad++; $display("FAIL play_load_c%0d: got %b want %b", i, oLoad, (i == 5)); end
    end
    total++; if (oKeyIdx !== 3'd0) begin bad++; $display("FAIL play_keyidx0: got %0d want 0", oKeyIdx); end
    total++; if (oActive !== 1'b1) begin bad++; $display("FAIL play_active: got %b want 1", oActive); end
    loads = 0;
    for (int j = 0; j < 20; j++) begin
      exp_t = 1'((j / 5) % 2);
      total++;
      if (oTone !== exp_t) begin bad++; $display("FAIL play_tone0_j%0d: got %b want %b", j, oTone, exp_t); end
      if (j > 0 && oLoad === 1'b1) loads++;
      step();
    end
    total++; if (loads !== 0) begin bad++; $display("FAIL play_extra_loads: got %0d want 0", loads); end
    iKeys = 8'h00;
    repeat (3) step();
    start_key(7);
    total++; if (oKeyIdx !== 3'd7) begin bad++; $display("FAIL play_keyidx7: got %0d want 7", oKeyIdx); end
    for (int j = 0; j < 8; j++) begin
      exp_t = 1'((j / 2) % 2);
      total++;
      if (oTone !== exp_t) begin bad++; $display("FAIL play_tone7_j%0d: got %b want %b", j, oTone, exp_t); end
      step();
    end
    iKeys = 8'h00;
    repeat (3) step();
  endtask

  task automatic test_glitch();
    iKeys = 8'h08;
    step();
    step();
    iKeys = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (oLoad !== 1'b0 || oActive !== 1'b0) begin
        bad++; $display("FAIL glitch_c%0d: got load=%b active=%b want 0 0", i, oLoad, oActive);
      end
    end
  endtask

  task automatic test_preempt();
    logic exp_t;
    start_key(5);
    repeat (4) step();
    total++; if (oTone !== 1'b1) begin bad++; $display("FAIL preempt_pre_tone: got %b want 1", oTone); end
    iKeys = 8'h24;
    step();
    total++; if (oKeyIdx !== 3'd2) begin bad++; $display("FAIL preempt_keyidx: got %0d want 2", oKeyIdx); end
    total++; if (oLoad !== 1'b1)   begin bad++; $display("FAIL preempt_load: got %b want 1", oLoad); end
    for (int j = 0; j < 8; j++) begin
      exp_t = 1'((j / 4) % 2);
      total++;
      if (oTone !== exp_t) begin bad++; $display("FAIL preempt_tone_j%0d: got %b want %b", j, oTone, exp_t); end
      if (j > 0) begin
        total++;
        if (oLoad !== 1'b0) begin bad++; $display("FAIL preempt_load_j%0d: got %b want 0", j, oLoad); end
      end
      step();
    end
    iKeys = 8'hA4;
    for (int j = 9; j < 16; j++) begin
      step();
      exp_t = 1'((j / 4) % 2);
      total++;
      if (oKeyIdx !== 3'd2 || oLoad !== 1'b0 || oTone !== exp_t) begin
        bad++; $display("FAIL higher_ignored_j%0d: got idx=%0d load=%b tone=%b want 2 0 %b", j, oKeyIdx, oLoad, oTone, exp_t);
      end
    end
    iKeys = 8'h00;
    repeat (3) step();
  endtask

  task automatic test_release_gap();
    start_key(3);
    repeat (6) step();
    iKeys = 8'h00;
    step();
    total++;
    if (oTone !== 1'b0 || oActive !== 1'b0) begin
      bad++; $display("FAIL gap_outputs: got tone=%b active=%b want 0 0", oTone, oActive);
    end
    iKeys = 8'h02;
    for (int s = 1; s <= 7; s++) begin
      step();
      total++;
      if (oLoad !== (s == 7)) begin bad++; $display("FAIL gap_len_s%0d: got load=%b want %b", s, oLoad, (s == 7)); end
    end
    total++; if (oKeyIdx !== 3'd1) begin bad++; $display("FAIL gap_next_keyidx: got %0d want 1", oKeyIdx); end
    iKeys = 8'h00;
    step();
    iKeys = 8'h10;
    step();
    iKeys = 8'h00;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (oLoad !== 1'b0 || oActive !== 1'b0) begin
        bad++; $display("FAIL gap_ignore_c%0d: got load=%b active=%b want 0 0", i, oLoad, oActive);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_key(0);
    repeat (6) step();
    total++; if (oTone !== 1'b1) begin bad++; $display("FAIL midreset_pre_tone: got %b want 1", oTone); end
    iKeys  = 8'hFF;
    iReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (oTone !== 1'b0 || oActive !== 1'b0 || oKeyIdx !== 3'd0 || oLoad !== 1'b0) begin
        bad++; $display("FAIL midreset_c%0d: got tone=%b active=%b idx=%0d load=%b want all 0", i, oTone, oActive, oKeyIdx, oLoad);
      end
    end
    iReset = 1'b0;
    step();
    total++; if (oActive !== 1'b0) begin bad++; $display("FAIL midreset_after: got active=%b want 0", oActive); end
    iKeys = 8'h00;
    step();
  endtask

`ifdef TONE_SUSTAIN_EN
  task automatic test_sustain();
    logic exp_t;
    start_key(0);
    repeat (2) step();
    iKeys = 8'h00;
    for (int s = 1; s <= 16; s++) begin
      step();
      exp_t = 1'(((2 + s) / 5) % 2);
      total++;
      if (oActive !== 1'b1 || oTone !== exp_t) begin
        bad++; $display("FAIL sustain_s%0d: got active=%b tone=%b want 1 %b", s, oActive, oTone, exp_t);
      end
    end
    step();
    total++;
    if (oActive !== 1'b0 || oTone !== 1'b0) begin
      bad++; $display("FAIL sustain_to_gap: got active=%b tone=%b want 0 0", oActive, oTone);
    end
    repeat (3) step();
    start_key(0);
    iKeys = 8'h00;
    repeat (5) step();
    iKeys = 8'h10;
    step();
    total++;
    if (oActive !== 1'b0 || oTone !== 1'b0) begin
      bad++; $display("FAIL sustain_to_arm: got active=%b tone=%b want 0 0", oActive, oTone);
    end
    repeat (4) step();
    total++;
    if (oKeyIdx !== 3'd4 || oLoad !== 1'b1) begin
      bad++; $display("FAIL sustain_replay: got idx=%0d load=%b want 4 1", oKeyIdx, oLoad);
    end
    iKeys = 8'h00;
    repeat (22) step();
  endtask
`endif

  initial begin
    iReset = 1'b1;
    iKeys  = 8'h00;
    test_reset();
    test_play();
    test_glitch();
    test_preempt();
`ifndef TONE_SUSTAIN_EN
    test_release_gap();
`endif
    test_reset_mid();
`ifdef TONE_SUSTAIN_EN
    test_sustain();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
